// File: rtl/mfp_pkg.sv
// Shared constants for the MFP interrupt blocks.
package mfp_pkg;

    localparam int unsigned MfpWidth = 16;

endpackage

// File: rtl/mfp_prio_enc.sv
// Highest-set-bit priority encoder: idx is the top set bit of req, 0 when none is set.
module mfp_prio_enc #(
    parameter int unsigned WIDTH = 16,
    localparam int unsigned VW = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] req,
    output logic [VW-1:0]    idx,
    output logic             valid
);

    // Ascending scan so the last (highest) set bit wins.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (req[i]) begin
                idx   = i[VW-1:0];
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mfp_irq_pending.sv
// Interrupt pending / in-service register with per-channel edge polarity,
// priority-encoded acknowledge and optional software end-of-interrupt.
module mfp_irq_pending
    import mfp_pkg::*;
#(
    parameter int unsigned WIDTH = MfpWidth,
    localparam int unsigned VW = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] src,
    input  logic [WIDTH-1:0] pol,
    input  logic [WIDTH-1:0] enable,
    input  logic [WIDTH-1:0] mask,
    input  logic [WIDTH-1:0] clr,
    input  logic             sei,
    input  logic [WIDTH-1:0] isr_clr,
    input  logic             ack,
    output logic [WIDTH-1:0] pending,
    output logic [WIDTH-1:0] in_service,
    output logic             irq,
    output logic [VW-1:0]    vec,
    output logic             ack_valid,
    output logic [VW-1:0]    ack_vec
);

    logic [WIDTH-1:0] src_q, clr_q, isr_clr_q;
    logic             ack_q;
    logic [WIDTH-1:0] pending_q, pending_d;
    logic [WIDTH-1:0] in_service_q, in_service_d;
    logic             ack_valid_q;
    logic [VW-1:0]    ack_vec_q, ack_vec_d;

    logic [WIDTH-1:0] src_event, clr_cond, isr_clr_rise, eligible, ack_onehot;
    logic             ack_accept;
    logic [VW-1:0]    enc_idx;
    logic             enc_valid;

    // A channel is blocked by any in-service channel at or above it.
    always_comb begin
        logic blocked;
        blocked  = 1'b0;
        eligible = '0;
        for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
            blocked     = blocked | in_service_q[i];
            eligible[i] = pending_q[i] & mask[i] & ~blocked;
        end
    end

    mfp_prio_enc #(
        .WIDTH (WIDTH)
    ) u_prio_enc (
        .req   (eligible),
        .idx   (enc_idx),
        .valid (enc_valid)
    );

    assign irq = enc_valid;
    assign vec = enc_idx;

    always_comb begin
        src_event    = (src ^ src_q) & ~(src ^ pol);
        clr_cond     = (clr & ~clr_q) | ~enable;
        isr_clr_rise = isr_clr & ~isr_clr_q;
        ack_accept   = ack & ~ack_q & irq;
        ack_onehot   = ack_accept ? ({{(WIDTH-1){1'b0}}, 1'b1} << vec) : '0;

        // A fresh source event beats the acknowledge clear so it is not lost.
        pending_d = ~clr_cond & ((src_event & enable) | (pending_q & ~ack_onehot));

        in_service_d = sei ? ((in_service_q | ack_onehot) & ~isr_clr_rise) : '0;

        ack_vec_d = ack_accept ? vec : ack_vec_q;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            src_q        <= src;
            clr_q        <= clr;
            isr_clr_q    <= isr_clr;
            ack_q        <= ack;
            pending_q    <= '0;
            in_service_q <= '0;
            ack_valid_q  <= 1'b0;
            ack_vec_q    <= '0;
        end else begin
            src_q        <= src;
            clr_q        <= clr;
            isr_clr_q    <= isr_clr;
            ack_q        <= ack;
            pending_q    <= pending_d;
            in_service_q <= in_service_d;
            ack_valid_q  <= ack_accept;
            ack_vec_q    <= ack_vec_d;
        end
    end

    assign pending    = pending_q;
    assign in_service = in_service_q;
    assign ack_valid  = ack_valid_q;
    assign ack_vec    = ack_vec_q;

endmodule

// File: tb/tb_mfp_irq_pending.sv
// Scoreboard bench for mfp_irq_pending: expectations are queued with each stimulus
// step and compared against the outputs sampled 1 time unit after the clock edge.
module tb_mfp_irq_pending;

    localparam int unsigned W  = 16;
    localparam int unsigned VW = 4;

    localparam int SelPend = 0;
    localparam int SelIsr  = 1;
    localparam int SelIrq  = 2;
    localparam int SelVec  = 3;
    localparam int SelAv   = 4;
    localparam int SelAvec = 5;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] val;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [W-1:0]  src, pol, enable, mask, clr, isr_clr;
    logic          sei, ack;
    logic [W-1:0]  pending, in_service;
    logic          irq, ack_valid;
    logic [VW-1:0] vec, ack_vec;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    mfp_irq_pending #(
        .WIDTH (W)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .src        (src),
        .pol        (pol),
        .enable     (enable),
        .mask       (mask),
        .clr        (clr),
        .sei        (sei),
        .isr_clr    (isr_clr),
        .ack        (ack),
        .pending    (pending),
        .in_service (in_service),
        .irq        (irq),
        .vec        (vec),
        .ack_valid  (ack_valid),
        .ack_vec    (ack_vec)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic expect_val(input string tag, input int sel, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.val = val;
        exp_q.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        logic [31:0] obs;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            case (e.sel)
                SelPend: obs = 32'(pending);
                SelIsr:  obs = 32'(in_service);
                SelIrq:  obs = 32'(irq);
                SelVec:  obs = 32'(vec);
                SelAv:   obs = 32'(ack_valid);
                default: obs = 32'(ack_vec);
            endcase
            check(e.tag, obs, e.val);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        drain();
    endtask

    task automatic expect_all_zero(input string tag);
        expect_val({tag, "_pend"}, SelPend, 0);
        expect_val({tag, "_isr"},  SelIsr,  0);
        expect_val({tag, "_irq"},  SelIrq,  0);
        expect_val({tag, "_vec"},  SelVec,  0);
        expect_val({tag, "_av"},   SelAv,   0);
        expect_val({tag, "_avec"}, SelAvec, 0);
    endtask

    initial begin
        reset_n = 1'b0;
        src     = '0;
        pol     = 16'hFFFF;
        enable  = 16'hFFFF;
        mask    = 16'hFFFF;
        clr     = '0;
        isr_clr = '0;
        sei     = 1'b0;
        ack     = 1'b0;
        step();
        expect_all_zero("reset");
        step();
        reset_n = 1'b1;

        // Rising edge on channel 5; falling edge is ignored.
        src[5] = 1'b1;
        expect_val("s5_pend", SelPend, 32'h0020);
        expect_val("s5_irq",  SelIrq,  1);
        expect_val("s5_vec",  SelVec,  5);
        step();
        src[5] = 1'b0;
        expect_val("s5_fall_pend", SelPend, 32'h0020);
        step();
        clr[5] = 1'b1;
        expect_val("clr5_pend", SelPend, 0);
        step();
        clr[5] = 1'b0;
        step();

        // Falling-edge channel 3 plus rising channel 9, then acknowledge.
        pol[3] = 1'b0;
        expect_val("pol_only_pend", SelPend, 0);
        step();
        src[3] = 1'b1;
        expect_val("s3_rise_pend", SelPend, 0);
        step();
        src[3] = 1'b0;
        src[9] = 1'b1;
        expect_val("s39_pend", SelPend, 32'h0208);
        expect_val("s39_vec",  SelVec,  9);
        step();
        ack = 1'b1;
        expect_val("ack9_av",   SelAv,   1);
        expect_val("ack9_avec", SelAvec, 9);
        expect_val("ack9_pend", SelPend, 32'h0008);
        expect_val("ack9_vec",  SelVec,  3);
        step();
        expect_val("ack_held_av",   SelAv,   0);
        expect_val("ack_held_pend", SelPend, 32'h0008);
        step();
        ack = 1'b0;
        step();

        // Software EOI: in-service bit 8 blocks channel 3 until cleared.
        sei    = 1'b1;
        src[8] = 1'b1;
        expect_val("s8_pend", SelPend, 32'h0108);
        expect_val("s8_vec",  SelVec,  8);
        step();
        ack = 1'b1;
        expect_val("ack8_isr",  SelIsr,  32'h0100);
        expect_val("ack8_pend", SelPend, 32'h0008);
        expect_val("ack8_irq",  SelIrq,  0);
        expect_val("ack8_avec", SelAvec, 8);
        expect_val("ack8_av",   SelAv,   1);
        step();
        ack = 1'b0;
        step();
        isr_clr[8] = 1'b1;
        expect_val("isrclr8_isr", SelIsr, 0);
        expect_val("isrclr8_irq", SelIrq, 1);
        expect_val("isrclr8_vec", SelVec, 3);
        step();
        isr_clr = '0;
        clr     = 16'hFFFF;
        step();
        clr = '0;
        expect_val("clr_all_pend", SelPend, 0);
        step();

        // Event beats acknowledge clear; clear beats event; disable clears.
        src[4] = 1'b1;
        expect_val("s4_pend", SelPend, 32'h0010);
        expect_val("s4_vec",  SelVec,  4);
        step();
        pol[4] = 1'b0;
        expect_val("pol4_pend", SelPend, 32'h0010);
        step();
        src[4] = 1'b0;
        ack    = 1'b1;
        expect_val("evack_pend", SelPend, 32'h0010);
        expect_val("evack_isr",  SelIsr,  32'h0010);
        expect_val("evack_irq",  SelIrq,  0);
        expect_val("evack_av",   SelAv,   1);
        expect_val("evack_avec", SelAvec, 4);
        step();
        ack = 1'b0;
        sei = 1'b0;
        expect_val("sei0_isr", SelIsr, 0);
        expect_val("sei0_irq", SelIrq, 1);
        expect_val("sei0_vec", SelVec, 4);
        expect_val("sei0_av",  SelAv,  0);
        step();
        pol[4] = 1'b1;
        expect_val("pol4b_pend", SelPend, 32'h0010);
        step();
        clr[4] = 1'b1;
        src[4] = 1'b1;
        expect_val("clrev_pend", SelPend, 0);
        step();
        clr    = '0;
        step();
        pol[4] = 1'b0;
        src[4] = 1'b0;
        expect_val("s4c_pend", SelPend, 32'h0010);
        step();
        enable[4] = 1'b0;
        expect_val("dis4_pend", SelPend, 0);
        step();
        enable = 16'hFFFF;
        expect_val("en4_pend", SelPend, 0);
        step();

        // Mask gates irq only; acknowledge with irq=0 is ignored.
        mask   = '0;
        src[0] = 1'b1;
        expect_val("mask_pend", SelPend, 32'h0001);
        expect_val("mask_irq",  SelIrq,  0);
        expect_val("mask_vec",  SelVec,  0);
        step();
        ack = 1'b1;
        expect_val("noack_av",   SelAv,   0);
        expect_val("noack_avec", SelAvec, 4);
        expect_val("noack_pend", SelPend, 32'h0001);
        step();
        ack  = 1'b0;
        mask = 16'h0001;
        #1;
        expect_val("unmask_irq", SelIrq, 1);
        expect_val("unmask_vec", SelVec, 0);
        drain();
        mask = 16'hFFFF;
        clr  = 16'hFFFF;
        step();
        clr = '0;
        expect_val("clr2_pend", SelPend, 0);
        step();

        // Build pending=FFFF, in_service=00F0, then reset.
        sei = 1'b1;
        pol = ~src;
        step();
        src = ~src;
        expect_val("all_pend", SelPend, 32'hFFFF);
        expect_val("all_vec",  SelVec,  15);
        step();
        for (int ch = 4; ch < 8; ch++) begin
            mask = 16'h0001 << ch;
            ack  = 1'b1;
            expect_val("ackch_avec", SelAvec, 32'(ch));
            step();
            ack = 1'b0;
            step();
        end
        mask = 16'hFFFF;
        expect_val("isrF0_isr",  SelIsr,  32'h00F0);
        expect_val("isrF0_pend", SelPend, 32'hFF0F);
        expect_val("isrF0_vec",  SelVec,  15);
        step();
        pol = pol ^ 16'h00F0;
        step();
        src = src ^ 16'h00F0;
        expect_val("refill_pend", SelPend, 32'hFFFF);
        step();
        reset_n = 1'b0;
        src     = 16'hFFFF;
        pol     = 16'hFFFF;
        expect_all_zero("rst2");
        step();
        reset_n = 1'b1;
        expect_val("post_rst_pend", SelPend, 0);
        expect_val("post_rst_irq",  SelIrq,  0);
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mfp_irq_pending.md
# mfp_irq_pending

Parametrised interrupt pending/in-service register for the MFP model. It generalises the 16-bit set/reset flip-flop in three ways: configurable channel count, per-channel edge polarity, and a priority-encoded acknowledge path with optional in-service tracking (software end-of-interrupt). It sits between the MFP's GPIO/timer/USART event sources and the CPU interrupt request/vector logic. Everything is clocked by the 32 MHz system clock.

## Interface
- WIDTH, 16, number of interrupt channels; bit WIDTH-1 has the highest priority
- VW, $clog2(WIDTH), vector index width (derived, not overridden)

- clk  in  1  system clock, 32 MHz
- reset_n  in  1  synchronous, active-low reset
- src  in  WIDTH  raw request lines from event sources
- pol  in  WIDTH  per-channel active edge: 1 = rising, 0 = falling
- enable  in  WIDTH  channel enable; 0 blocks new events and clears pending
- mask  in  WIDTH  channel mask; gates irq/vec only, never pending
- clr  in  WIDTH  pending clear; acts on rising edge of each bit
- sei  in  1  software EOI mode; 1 = acknowledge sets in-service bit
- isr_clr  in  WIDTH  in-service clear; acts on rising edge of each bit
- ack  in  1  CPU interrupt acknowledge; acts on rising edge
- pending  out  WIDTH  pending register
- in_service  out  WIDTH  in-service register
- irq  out  1  interrupt request to CPU
- vec  out  VW  index of the highest-priority eligible channel (0 when irq=0)
- ack_valid  out  1  one-cycle pulse when an acknowledge was accepted
- ack_vec  out  VW  channel index captured on the accepted acknowledge

## Operation
- Source event on bit i: src[i] differs from its previous sample and src[i]==pol[i]. Changing pol with src steady creates no event.
- Clear condition for pending[i]: rising edge of clr[i], or enable[i]==0.
- pending[i] priority, highest first:
  - clear condition → 0
  - source event with enable[i]=1 → 1 (wins over an acknowledge clear, so the new event is not lost)
  - acknowledge accepted with ack_vec==i → 0
  - otherwise hold
- Eligible bit i: pending[i] & mask[i], and no in_service[j] set for any j>=i.
- irq = any eligible bit. vec = highest eligible index. Both are combinational from registers.
- Acknowledge: on ack rising edge with irq=1:
  - ack_vec <= vec and ack_valid <= 1 for exactly one cycle
  - pending[vec] cleared
  - in_service[vec] set if sei=1
  - With irq=0 the acknowledge is ignored: ack_valid stays 0 and ack_vec holds.
- in_service[i] is cleared by a rising edge of isr_clr[i], or by sei=0 (whole register held at 0). If a set and a clear of the same bit occur in one cycle, the clear wins.
- Reset (reset_n=0 at a clock edge):
  - pending, in_service, ack_valid, ack_vec all 0, so irq=0 and vec=0
  - src, clr, isr_clr and ack edge registers load their current inputs, so no spurious edge on the first cycle after reset
  - Reset overrides every event in flight.

## Timing
- Edge latency: src change settled before clock edge k → pending set after edge k → irq/vec valid in the same cycle.
- ack, clr and isr_clr rising edges detected against the previous-cycle sample. Effect visible after that edge; single-cycle or multi-cycle strobes behave identically.
- ack_valid is high exactly one cycle after the accepting edge. A held ack does not re-acknowledge.
- A mask change affects irq/vec combinationally in the same cycle.

## Structure
- Package mfp_pkg: no typedefs required.
- Sub-module mfp_prio_enc (parameter WIDTH): combinational highest-set-bit encoder producing index and valid. Used once for the eligible vector.
- Edge detection and the registers stay in the top module.

## Test plan
- WIDTH=16, pol=all 1, enable=FFFF, mask=FFFF: src[5] 0→1 → pending=0x0020 and irq=1 after one edge, vec=5; src[5] 1→0 → no change.
- pol[3]=0, src[3] 1→0 and src[9] 0→1 in the same cycle → pending=0x0208, vec=9; ack pulse → ack_vec=9, ack_valid for one cycle, pending=0x0008, vec=3.
- sei=1, pending=0x0108, ack → in_service=0x0100, irq=0 (bit 3 blocked); isr_clr[8] edge → irq=1, vec=3.
- Simultaneous src[4] event and accepted ack of channel 4 → pending[4] stays 1. Simultaneous clr[4] edge and src[4] event → pending[4]=0. enable[4]=0 with pending[4]=1 → pending[4]=0 next cycle.
- mask=0 with pending=0x0001 → irq=0 while pending holds 0x0001. ack with irq=0 → no ack_valid.
- reset_n low while pending=0xFFFF and in_service=0x00F0 → all outputs 0. src held high through reset → no event on release.
